ahb_sram_responder: RTL and testbench
=====================================

// Module: ahb_sram_responder
// PURPOSE
//  AHB-Lite subordinate (responder) fronting a word-organised SRAM; the target end of the DMAC master port.
//  Decodes address phases, inserts programmable wait states, performs byte-strobed writes and registered reads.
//  Flags out-of-range/misaligned/oversize accesses with the two-cycle AHB ERROR response.
//  Used as source and destination memory for DMAC system benches and as on-chip scratch RAM.
// PARAMETERS
//  MEM_DEPTH    256  number of 32-bit words; valid byte range 0 .. MEM_DEPTH*4-1 (offset within HSel window)
//  WAIT_STATES  0    HReadyOut-low cycles inserted in every OKAY data phase (0..15)
//  ADDR_LSB_W   12   HAddr bits used for decode; higher bits ignored (window select is external via HSel)
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  HSel       in   1   slave select from address decoder
//  HAddr      in   32  byte address (address phase)
//  HTrans     in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  HWrite     in   1   1 = write transfer
//  HSize      in   3   000 byte, 001 halfword, 010 word; others illegal
//  HWStrb     in   4   byte-lane write strobes (data phase, sampled with HWData)
//  HWData     in   32  write data (data phase)
//  HReady     in   1   bus-wide ready; address phase valid only when high
//  HRData     out  32  read data, valid when HReadyOut=1 in an OKAY read data phase
//  HReadyOut  out  1   0 = extend current data phase
//  HResp      out  2   00 OKAY, 01 ERROR
// BEHAVIOUR
//  Reset: HReadyOut=1, HResp=00, HRData=0, FSM=IDLE, wait counter=0; memory contents NOT cleared.
//  Accept: address phase taken on a clk edge where HSel & HReady & HTrans[1]; latch addr, write, size, legality.
//  IDLE/BUSY or !HSel: no transfer; next cycle HReadyOut=1, HResp=OKAY (zero-wait).
//  Legality: illegal if HAddr[ADDR_LSB_W-1:0] >= MEM_DEPTH*4, HSize>010, word with addr[1:0]!=0, half with addr[0]!=0.
//  FSM states: IDLE, WAIT, ERR1, ERR2.
//   IDLE  : HReadyOut=1; on legal accept with WAIT_STATES>0 -> WAIT (cnt=WAIT_STATES); legal & 0 -> stay IDLE;
//           illegal accept -> ERR1.
//   WAIT  : HReadyOut=0, HResp=00; cnt decrements; cnt==1 -> IDLE (final cycle has HReadyOut=1).
//   ERR1  : HReadyOut=0, HResp=01 -> ERR2.   ERR2 : HReadyOut=1, HResp=01 -> IDLE (or new accept).
//  Pipelining: a new address phase may be accepted on the edge that completes a data phase (HReadyOut=1);
//   accept decisions in ERR2 follow IDLE rules. No accept while HReadyOut=0.
//  OKAY latency: 1+WAIT_STATES cycles from address-phase edge to completing edge.
//  Read: mem[addr[ADDR_LSB_W-1:2]] registered into HRData on the edge entering the completing cycle; full word
//   returned regardless of HSize (master selects lanes). HRData holds last value otherwise.
//  Write: on completing edge, byte lane i written iff HWStrb[i]; HSize does not gate lanes. ERROR: no write.
//  Hazard: read whose data is registered on the same edge as a write commit to the same word returns the merged
//   (post-write) word -- forwarding required.
//  HWStrb==0000 on a write: OKAY completion, memory unchanged.
//  Reset asserted mid-WAIT/ERR: transfer abandoned, no write, outputs to reset values next edge.
//  Address wrap: HAddr bits >= ADDR_LSB_W ignored; no wrap inside the array (beyond depth = ERROR).
// STRUCTURE
//  ahb_pkg: htrans_t / hresp_t / hsize_t enums and codes, responder FSM state enum.
//  Sub-module ahb_strobe_ram: MEM_DEPTH x 32 array, one byte-enabled write port, one read port with same-edge
//   write-to-read forwarding; exposes array as `mem` for bench back-door preload/check.
//  Top holds decode, legality check, wait counter, FSM, output registers.
// TESTING
//  1 WAIT_STATES=0, NONSEQ word write 0x10=0xAABBCCDD strb 1111, then read 0x10 -> HReadyOut never low, HRData=0xAABBCCDD.
//  2 WAIT_STATES=3, single read 0x4 -> HReadyOut low exactly 3 cycles, then high with HRData=mem[1], HResp=00.
//  3 Byte write 0x21 data 0x0000EE00 strb 0010 over word 0x11223344 -> mem[8]=0x1122EE44.
//  4 Read 0x400 (MEM_DEPTH=256) -> HResp=01 two cycles, HReadyOut 0 then 1; word at 0x2 -> ERROR; mem unchanged.
//  5 Back-to-back write 0x8=0x55667788 then read 0x8 pipelined -> HRData=0x55667788 (forwarding); 10-beat SEQ burst
//    matches preloaded data.
//  6 rst pulsed during WAIT of write 0xC=0xDEADBEEF -> mem[3] unchanged; HReadyOut=1, HResp=00 after reset edge.

Source files
------------

// File: rtl/ahb_sram_responder_pkg.sv
// Shared types for the AHB-Lite SRAM responder: bus encodings, FSM states and
// the size/alignment helper used during address-phase decode.
package ahb_sram_responder_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } rsp_state_t;

    // Wait counter width: covers WAIT_STATES 0..15
    localparam int WAIT_CNT_W = 4;

    // True when the transfer size is supported and naturally aligned
    function automatic logic size_align_ok(input logic [2:0] hsize, input logic [1:0] addr_lo);
        logic ok;
        case (hsize)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = (addr_lo[0] == 1'b0);
            HSIZE_WORD: ok = (addr_lo == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahb_sram_responder_if.sv
// AHB-Lite signal bundle between a master (or interconnect) and the SRAM responder.
interface ahb_sram_responder_if;
    logic        HSel;
    logic [31:0] HAddr;
    logic [1:0]  HTrans;
    logic        HWrite;
    logic [2:0]  HSize;
    logic [3:0]  HWStrb;
    logic [31:0] HWData;
    logic        HReady;
    logic [31:0] HRData;
    logic        HReadyOut;
    logic [1:0]  HResp;

    modport master (
        output HSel, HAddr, HTrans, HWrite, HSize, HWStrb, HWData, HReady,
        input  HRData, HReadyOut, HResp
    );

    modport slave (
        input  HSel, HAddr, HTrans, HWrite, HSize, HWStrb, HWData, HReady,
        output HRData, HReadyOut, HResp
    );
endinterface

// File: rtl/ahb_sram_responder_strobe_ram.sv
// Word-organised RAM with one byte-enabled write port and one registered read
// port. A read registered on the same edge as a write to the same word returns
// the merged post-write word. The array is named `mem` for back-door access.
module ahb_strobe_ram #(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [3:0]       wstrb,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata
);
    logic [31:0] mem [DEPTH];
    logic        hit_s;
    logic [31:0] fwd_s;
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    // Read path: merge write lanes landing on the same word this edge
    always_comb begin
        hit_s = we && (widx == ridx);
        for (int i = 0; i < 4; i++) begin
            fwd_s[8*i +: 8] = (hit_s && wstrb[i]) ? wdata[8*i +: 8] : mem[ridx][8*i +: 8];
        end
        rdata_d = re ? fwd_s : rdata_q;
    end

    // Byte-lane writes; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read data register, holds its value between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'h0000_0000;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/ahb_sram_responder.sv
// AHB-Lite responder in front of a word SRAM: address-phase decode, legality
// check, programmable wait states, two-cycle ERROR response and registered reads.
module ahb_sram_responder
    import ahb_sram_responder_pkg::*;
#(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_LSB_W  = 12
) (
    input  logic                clk,
    input  logic                rst,
    ahb_sram_responder_if.slave bus
);
    localparam int                    IDX_W      = $clog2(MEM_DEPTH);
    localparam logic [ADDR_LSB_W:0]   BYTE_LIMIT = (ADDR_LSB_W + 1)'(MEM_DEPTH * 4);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD  = WAIT_CNT_W'(WAIT_STATES);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE    = WAIT_CNT_W'(1);
    localparam logic [WAIT_CNT_W-1:0] CNT_ZERO   = WAIT_CNT_W'(0);
    localparam logic                  HAS_WAITS  = (WAIT_STATES > 0);

    rsp_state_t             state_q, state_d;
    logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d;
    logic                   dp_act_q, dp_act_d;
    logic                   dp_write_q, dp_write_d;
    logic [IDX_W-1:0]       dp_idx_q, dp_idx_d;
    logic                   hreadyout_q, hreadyout_d;
    hresp_t                 hresp_q, hresp_d;

    logic                   accept_s;
    logic                   in_range_s;
    logic                   legal_s;
    logic [IDX_W-1:0]       acc_idx_s;
    logic                   complete_s;
    logic                   ram_we_s;
    logic                   ram_re_s;
    logic [IDX_W-1:0]       ram_ridx_s;
    logic [31:0]            ram_rdata_s;
    logic                   unused_bus_bits_s;

    // Bits outside the decode window and the BUSY/IDLE distinction play no role
    assign unused_bus_bits_s = ^{bus.HAddr[31:ADDR_LSB_W], bus.HTrans[0]};

    // Address-phase decode and completion of the current OKAY data phase
    always_comb begin
        accept_s   = bus.HSel & bus.HReady & bus.HTrans[1] & hreadyout_q;
        in_range_s = ({1'b0, bus.HAddr[ADDR_LSB_W-1:0]} < BYTE_LIMIT);
        legal_s    = in_range_s & size_align_ok(bus.HSize, bus.HAddr[1:0]);
        acc_idx_s  = bus.HAddr[IDX_W+1:2];
        complete_s = dp_act_q & hreadyout_q;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; ERR2 completes a data phase so it accepts like IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (accept_s && !legal_s) begin
                    state_d = ST_ERR1;
                end else if (accept_s && HAS_WAITS) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs, computed from the next state so they leave a register
    always_comb begin
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        case (state_d)
            ST_IDLE: begin hreadyout_d = 1'b1; hresp_d = HRESP_OKAY;  end
            ST_WAIT: begin hreadyout_d = 1'b0; hresp_d = HRESP_OKAY;  end
            ST_ERR1: begin hreadyout_d = 1'b0; hresp_d = HRESP_ERROR; end
            ST_ERR2: begin hreadyout_d = 1'b1; hresp_d = HRESP_ERROR; end
            default: begin hreadyout_d = 1'b1; hresp_d = HRESP_OKAY;  end
        endcase
    end

    // Wait counter, latched data-phase context and RAM port control
    always_comb begin
        if ((state_d == ST_WAIT) && (state_q != ST_WAIT)) begin
            cnt_d = WAIT_LOAD;
        end else if (state_q == ST_WAIT) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = CNT_ZERO;
        end

        if (hreadyout_q) begin
            dp_act_d = accept_s & legal_s;
            if (accept_s) begin
                dp_write_d = bus.HWrite;
                dp_idx_d   = acc_idx_s;
            end else begin
                dp_write_d = dp_write_q;
                dp_idx_d   = dp_idx_q;
            end
        end else begin
            dp_act_d   = dp_act_q;
            dp_write_d = dp_write_q;
            dp_idx_d   = dp_idx_q;
        end

        ram_we_s = complete_s & dp_write_q & ~rst;
        if (HAS_WAITS) begin
            // Read data lands on the edge that enters the final (ready) cycle
            ram_re_s   = (state_q == ST_WAIT) && (cnt_q == CNT_ONE) && !dp_write_q;
            ram_ridx_s = dp_idx_q;
        end else begin
            // Zero-wait: data is registered on the address-phase edge itself
            ram_re_s   = accept_s & legal_s & ~bus.HWrite;
            ram_ridx_s = acc_idx_s;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= CNT_ZERO;
            dp_act_q    <= 1'b0;
            dp_write_q  <= 1'b0;
            dp_idx_q    <= {IDX_W{1'b0}};
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            cnt_q       <= cnt_d;
            dp_act_q    <= dp_act_d;
            dp_write_q  <= dp_write_d;
            dp_idx_q    <= dp_idx_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    ahb_strobe_ram #(
        .DEPTH (MEM_DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we_s),
        .widx  (dp_idx_q),
        .wstrb (bus.HWStrb),
        .wdata (bus.HWData),
        .re    (ram_re_s),
        .ridx  (ram_ridx_s),
        .rdata (ram_rdata_s)
    );

    assign bus.HReadyOut = hreadyout_q;
    assign bus.HResp     = hresp_q;
    assign bus.HRData    = ram_rdata_s;
endmodule

// File: tb/tb_ahb_sram_responder.sv
// Directed bench for ahb_sram_responder: one zero-wait and one 3-wait instance,
// a reference memory model and an in-order scoreboard of data-phase results.
module tb_ahb_sram_responder;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cmd_t;

    typedef struct {
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] addr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hwstrb;
    logic [31:0] hwdata;

    logic        ro;
    logic [1:0]  rsp;
    logic [31:0] rdat;

    int          n_assert;
    int          n_fail;
    cmd_t        cmd_q[$];
    exp_t        exp_q[$];
    logic [31:0] ref_mem [2][256];

    ahb_sram_responder_if if0 ();
    ahb_sram_responder_if if3 ();

    assign if0.HSel   = hsel & ~sel;
    assign if3.HSel   = hsel & sel;
    assign if0.HAddr  = haddr;   assign if3.HAddr  = haddr;
    assign if0.HTrans = htrans;  assign if3.HTrans = htrans;
    assign if0.HWrite = hwrite;  assign if3.HWrite = hwrite;
    assign if0.HSize  = hsize;   assign if3.HSize  = hsize;
    assign if0.HWStrb = hwstrb;  assign if3.HWStrb = hwstrb;
    assign if0.HWData = hwdata;  assign if3.HWData = hwdata;
    assign if0.HReady = if0.HReadyOut;
    assign if3.HReady = if3.HReadyOut;

    assign ro   = sel ? if3.HReadyOut : if0.HReadyOut;
    assign rsp  = sel ? if3.HResp     : if0.HResp;
    assign rdat = sel ? if3.HRData    : if0.HRData;

    ahb_sram_responder #(.MEM_DEPTH(256), .WAIT_STATES(0), .ADDR_LSB_W(12)) dut0 (
        .clk (clk), .rst (rst), .bus (if0)
    );
    ahb_sram_responder #(.MEM_DEPTH(256), .WAIT_STATES(3), .ADDR_LSB_W(12)) dut3 (
        .clk (clk), .rst (rst), .bus (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_legal(input logic [31:0] a, input logic [2:0] s);
        return !((a[11:0] >= 12'h400) || (s > 3'b010) ||
                 ((s == 3'b010) && (a[1:0] != 2'b00)) ||
                 ((s == 3'b001) && a[0]));
    endfunction

    task automatic add(input logic wr, input logic [31:0] a, input logic [2:0] s,
                       input logic [1:0] t, input logic [31:0] d, input logic [3:0] b);
        cmd_t c;
        c.wr = wr; c.addr = a; c.size = s; c.trans = t; c.wdata = d; c.wstrb = b;
        cmd_q.push_back(c);
    endtask

    // Model the effect of an accepted address phase and queue its expected result
    task automatic model_accept(input cmd_t c);
        exp_t       e;
        logic       lg;
        logic [7:0] idx;
        int         s;
        s   = sel ? 1 : 0;
        lg  = is_legal(c.addr, c.size);
        idx = c.addr[9:2];
        e.err    = !lg;
        e.waits  = lg ? (sel ? 3 : 0) : 1;
        e.chk_rd = lg && !c.wr;
        e.rdata  = 32'h0;
        e.addr   = c.addr;
        if (lg && c.wr) begin
            for (int i = 0; i < 4; i++) begin
                if (c.wstrb[i]) ref_mem[s][idx][8*i +: 8] = c.wdata[8*i +: 8];
            end
        end
        if (e.chk_rd) e.rdata = ref_mem[s][idx];
        exp_q.push_back(e);
    endtask

    // Drive queued commands back-to-back (pipelined) and score each data phase
    task automatic do_seq();
        cmd_t       dp_cmd;
        cmd_t       c;
        exp_t       e;
        logic       dp_act;
        int         low;
        logic [1:0] low_resp;
        int         cyc;
        dp_act = 1'b0; low = 0; low_resp = 2'b00; cyc = 0;
        while (((cmd_q.size() > 0) || dp_act) && (cyc < 300)) begin
            @(posedge clk); #1;
            if (cmd_q.size() > 0) begin
                c = cmd_q[0];
                hsel = 1'b1; haddr = c.addr; htrans = c.trans; hwrite = c.wr; hsize = c.size;
            end else begin
                hsel = 1'b0; htrans = 2'b00;
            end
            if (dp_act) begin
                hwdata = dp_cmd.wdata; hwstrb = dp_cmd.wstrb;
            end else begin
                hwdata = 32'h0; hwstrb = 4'h0;
            end
            @(negedge clk);
            if (!ro) begin
                low++;
                low_resp = rsp;
            end else begin
                if (dp_act) begin
                    e = exp_q.pop_front();
                    chk($sformatf("resp@%h", e.addr), {30'h0, rsp}, e.err ? 32'h1 : 32'h0);
                    chk($sformatf("waits@%h", e.addr), 32'(low), 32'(e.waits));
                    if (e.waits > 0)
                        chk($sformatf("wait_resp@%h", e.addr), {30'h0, low_resp}, e.err ? 32'h1 : 32'h0);
                    if (e.chk_rd)
                        chk($sformatf("rdata@%h", e.addr), rdat, e.rdata);
                end
                if (cmd_q.size() > 0) begin
                    dp_cmd = cmd_q.pop_front();
                    dp_act = 1'b1;
                    model_accept(dp_cmd);
                end else begin
                    dp_act = 1'b0;
                end
                low = 0;
            end
            cyc++;
        end
        chk("seq_done", 32'(cmd_q.size()) + {31'h0, dp_act}, 32'h0);
        cmd_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0; hwstrb = 4'h0;
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        rst = 1'b1; sel = 1'b0; hsel = 1'b0; haddr = 32'h0; htrans = 2'b00;
        hwrite = 1'b0; hsize = 3'b010; hwstrb = 4'h0; hwdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Reset state of both instances
        chk("rst_rdy0",  {31'h0, if0.HReadyOut}, 32'h1);
        chk("rst_resp0", {30'h0, if0.HResp},     32'h0);
        chk("rst_data0", if0.HRData,             32'h0);
        chk("rst_rdy3",  {31'h0, if3.HReadyOut}, 32'h1);
        chk("rst_resp3", {30'h0, if3.HResp},     32'h0);
        chk("rst_data3", if3.HRData,             32'h0);

        // Zero-wait instance: word write then read
        sel = 1'b0;
        add(1'b1, 32'h10, 3'b010, 2'b10, 32'hAABBCCDD, 4'hF);
        add(1'b0, 32'h10, 3'b010, 2'b10, 32'h0, 4'h0);
        do_seq();

        // Byte write merges into an existing word
        add(1'b1, 32'h20, 3'b010, 2'b10, 32'h11223344, 4'hF);
        add(1'b1, 32'h21, 3'b000, 2'b10, 32'h0000EE00, 4'b0010);
        add(1'b0, 32'h20, 3'b010, 2'b10, 32'h0, 4'h0);
        do_seq();
        chk("mem8", dut0.u_ram.mem[8], 32'h1122EE44);

        // Forwarding, zero-strobe write, halfword write, last word, window wrap
        add(1'b1, 32'h08, 3'b010, 2'b10, 32'h55667788, 4'hF);
        add(1'b0, 32'h08, 3'b010, 2'b10, 32'h0, 4'h0);
        add(1'b1, 32'h10, 3'b010, 2'b10, 32'h12345678, 4'h0);
        add(1'b0, 32'h10, 3'b010, 2'b10, 32'h0, 4'h0);
        add(1'b1, 32'h12, 3'b001, 2'b10, 32'h99880000, 4'b1100);
        add(1'b0, 32'h10, 3'b010, 2'b10, 32'h0, 4'h0);
        add(1'b1, 32'h3FC, 3'b010, 2'b10, 32'hFEEDFACE, 4'hF);
        add(1'b0, 32'h3FC, 3'b010, 2'b10, 32'h0, 4'h0);
        add(1'b0, 32'h1010, 3'b010, 2'b10, 32'h0, 4'h0);
        do_seq();

        // 10-beat write burst, then 10-beat read burst
        for (int i = 0; i < 10; i++)
            add(1'b1, 32'h40 + 32'(4 * i), 3'b010, (i == 0) ? 2'b10 : 2'b11,
                32'hC0DE0000 + 32'(i * 32'h111), 4'hF);
        for (int i = 0; i < 10; i++)
            add(1'b0, 32'h40 + 32'(4 * i), 3'b010, (i == 0) ? 2'b10 : 2'b11, 32'h0, 4'h0);
        do_seq();

        // Illegal accesses: out of range, misaligned, oversize; memory untouched
        add(1'b1, 32'h00, 3'b010, 2'b10, 32'h01020304, 4'hF);
        add(1'b0, 32'h400, 3'b010, 2'b10, 32'h0, 4'h0);
        add(1'b1, 32'h02, 3'b010, 2'b10, 32'hFFFFFFFF, 4'hF);
        add(1'b1, 32'h01, 3'b001, 2'b10, 32'hFFFFFFFF, 4'hF);
        add(1'b0, 32'h00, 3'b011, 2'b10, 32'h0, 4'h0);
        add(1'b1, 32'h800, 3'b010, 2'b10, 32'hFFFFFFFF, 4'hF);
        add(1'b0, 32'h00, 3'b010, 2'b10, 32'h0, 4'h0);
        do_seq();
        chk("mem0", dut0.u_ram.mem[0], 32'h01020304);

        // Three-wait instance: waits on writes and reads, error stays two cycles
        sel = 1'b1;
        add(1'b1, 32'h04, 3'b010, 2'b10, 32'hCAFEF00D, 4'hF);
        add(1'b0, 32'h04, 3'b010, 2'b10, 32'h0, 4'h0);
        add(1'b0, 32'h400, 3'b010, 2'b10, 32'h0, 4'h0);
        add(1'b1, 32'h0C, 3'b010, 2'b10, 32'h0BADF00D, 4'hF);
        add(1'b0, 32'h04, 3'b010, 2'b10, 32'h0, 4'h0);
        do_seq();
        chk("mem1_w3", dut3.u_ram.mem[1], 32'hCAFEF00D);

        // Reset during the wait states of a write abandons it
        @(posedge clk); #1;
        hsel = 1'b1; haddr = 32'h0C; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'hDEADBEEF; hwstrb = 4'hF;
        @(negedge clk);
        chk("t6_wait_low", {31'h0, ro}, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_rdy",  {31'h0, ro}, 32'h1);
        chk("t6_resp", {30'h0, rsp}, 32'h0);
        chk("t6_data", rdat, 32'h0);
        repeat (6) @(posedge clk);
        #1 hwdata = 32'h0; hwstrb = 4'h0;
        chk("t6_mem3", dut3.u_ram.mem[3], 32'h0BADF00D);
        add(1'b0, 32'h0C, 3'b010, 2'b10, 32'h0, 4'h0);
        do_seq();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
